// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit:
// addresses, CSR op encoding, trap FSM states, cause codes, status bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRAP = 2'b01,
    ST_MRET = 2'b10
  } csr_state_e;

  localparam int unsigned CAUSE_W   = 5;
  localparam logic [CAUSE_W-1:0] CAUSE_MSI = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MTI = 5'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_MEI = 5'd11;

  // Bit positions shared by mie/mip (same as the cause numbers)
  localparam int unsigned IRQ_MSI_BIT = 3;
  localparam int unsigned IRQ_MTI_BIT = 7;
  localparam int unsigned IRQ_MEI_BIT = 11;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

endpackage

// File: rtl/csr_counter.sv
// Wrapping performance counter of CNT_W bits, exposed as two XLEN halves.
// A write to either half replaces the increment of the whole counter that cycle.
module csr_counter #(
  parameter int unsigned CNT_W = 64,
  parameter int unsigned XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  input  logic            i_wr_lo,
  input  logic            i_wr_hi,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_lo,
  output logic [XLEN-1:0] o_hi
);

  localparam int unsigned EXT_W = 2 * XLEN;

  logic [CNT_W-1:0] r_cnt;
  logic [EXT_W-1:0] w_ext;
  logic [EXT_W-1:0] w_wr;

  assign w_ext = EXT_W'(r_cnt);

  // Merge the written half with the untouched half
  always_comb begin
    w_wr = w_ext;
    if (i_wr_lo) w_wr[XLEN-1:0]     = i_wdata;
    if (i_wr_hi) w_wr[EXT_W-1:XLEN] = i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      r_cnt <= CNT_W'(w_wr);
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_lo = w_ext[XLEN-1:0];
  assign o_hi = w_ext[EXT_W-1:XLEN];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file for the execute stage: CSR read/modify/write, interrupt
// synchronisation and priority, and the trap-entry/MRET redirect sequencer.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     ADDRW       = 12,
  parameter int unsigned     CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADDRW-1:0] csr_addr_i,
  input  logic [1:0]       csr_op_i,
  input  logic [XLEN-1:0]  csr_wdata_i,
  output logic [XLEN-1:0]  csr_rdata_o,
  output logic             csr_illegal_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             pc_valid_i,
  input  logic             instr_ret_i,
  input  logic             mret_i,
  input  logic             irq_ext_i,
  input  logic             irq_tmr_i,
  input  logic             irq_sw_i,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o
);

  localparam bit              HAS_HI    = (CNT_W > XLEN);
  localparam logic [XLEN-1:0] MIE_MASK  = XLEN'(12'h888);
  localparam logic [XLEN-1:0] ALIGN4    = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_INI = VECTORED_EN ? MTVEC_RST : (MTVEC_RST & ALIGN4);

  csr_op_e          w_op;
  csr_state_e       r_state, w_state_nxt;

  logic [XLEN-1:0]  r_mtvec, r_mscratch, r_mepc, r_mcause, r_mie;
  logic             r_st_mie, r_st_mpie;
  logic [2:0]       r_irq_meta, r_irq_sync;   // {ext, tmr, sw}
  logic             r_redirect, w_redirect_nxt;
  logic [XLEN-1:0]  r_redirect_pc, w_redirect_pc_nxt;

  logic [XLEN-1:0]  w_mstatus, w_mip, w_irq_act;
  logic             w_irq_pend;
  logic [CAUSE_W-1:0] w_cause;
  logic [XLEN-1:0]  w_trap_pc;

  logic [XLEN-1:0]  w_old, w_new;
  logic             w_hit, w_is_mip, w_wr_req, w_illegal, w_we;
  logic             w_trap_take, w_mret_take;
  logic [XLEN-1:0]  w_mcycle_lo, w_mcycle_hi, w_minstret_lo, w_minstret_hi;

  assign w_op = csr_op_e'(csr_op_i);

  // Two-flop synchronisers for the asynchronous interrupt lines
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_meta <= '0;
      r_irq_sync <= '0;
    end else begin
      r_irq_meta <= {irq_ext_i, irq_tmr_i, irq_sw_i};
      r_irq_sync <= r_irq_meta;
    end
  end

  always_comb begin
    w_mip              = '0;
    w_mip[IRQ_MEI_BIT] = r_irq_sync[2];
    w_mip[IRQ_MTI_BIT] = r_irq_sync[1];
    w_mip[IRQ_MSI_BIT] = r_irq_sync[0];
    w_mstatus                                 = '0;
    w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    w_mstatus[MSTATUS_MPIE_BIT]               = r_st_mpie;
    w_mstatus[MSTATUS_MIE_BIT]                = r_st_mie;
  end

  // Pending interrupt selection: ext > sw > tmr
  always_comb begin
    w_irq_act  = w_mip & r_mie;
    w_irq_pend = r_st_mie & (|w_irq_act);
    if (w_irq_act[IRQ_MEI_BIT])      w_cause = CAUSE_MEI;
    else if (w_irq_act[IRQ_MSI_BIT]) w_cause = CAUSE_MSI;
    else                             w_cause = CAUSE_MTI;
    w_trap_pc = r_mtvec & ALIGN4;
    if (VECTORED_EN && (r_mtvec[1:0] == 2'b01)) begin
      w_trap_pc = (r_mtvec & ALIGN4) + XLEN'({w_cause, 2'b00});
    end
  end

  // CSR read mux and address decode
  always_comb begin
    w_old    = '0;
    w_hit    = 1'b1;
    w_is_mip = 1'b0;
    case (csr_addr_i)
      ADDRW'(CSR_MSTATUS):   w_old = w_mstatus;
      ADDRW'(CSR_MIE):       w_old = r_mie;
      ADDRW'(CSR_MTVEC):     w_old = r_mtvec;
      ADDRW'(CSR_MSCRATCH):  w_old = r_mscratch;
      ADDRW'(CSR_MEPC):      w_old = r_mepc;
      ADDRW'(CSR_MCAUSE):    w_old = r_mcause;
      ADDRW'(CSR_MIP): begin
        w_old    = w_mip;
        w_is_mip = 1'b1;
      end
      ADDRW'(CSR_MCYCLE):    w_old = w_mcycle_lo;
      ADDRW'(CSR_MINSTRET):  w_old = w_minstret_lo;
      ADDRW'(CSR_MCYCLEH): begin
        w_old = w_mcycle_hi;
        w_hit = HAS_HI;
      end
      ADDRW'(CSR_MINSTRETH): begin
        w_old = w_minstret_hi;
        w_hit = HAS_HI;
      end
      default:               w_hit = 1'b0;
    endcase
  end

  // RS/RC with a zero mask is a pure read and never writes
  always_comb begin
    w_new    = w_old;
    w_wr_req = 1'b0;
    case (w_op)
      CSR_RW: begin
        w_new    = csr_wdata_i;
        w_wr_req = 1'b1;
      end
      CSR_RS: begin
        w_new    = w_old | csr_wdata_i;
        w_wr_req = |csr_wdata_i;
      end
      CSR_RC: begin
        w_new    = w_old & ~csr_wdata_i;
        w_wr_req = |csr_wdata_i;
      end
      default: ;
    endcase
    w_illegal = (w_op != CSR_NONE) && (!w_hit || (w_is_mip && w_wr_req));
    // Writes from instructions being flushed by a trap or redirect are dropped
    w_we      = w_wr_req && !w_illegal && (r_state == ST_RUN) && !w_trap_take;
  end

  assign csr_rdata_o   = ((w_op == CSR_NONE) || w_illegal) ? '0 : w_old;
  assign csr_illegal_o = w_illegal;

  // Trap/MRET sequencer: next state and redirect
  always_comb begin
    w_state_nxt       = r_state;
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_trap_take       = 1'b0;
    w_mret_take       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_irq_pend && pc_valid_i) begin
          w_state_nxt       = ST_TRAP;
          w_trap_take       = 1'b1;
          w_redirect_nxt    = 1'b1;
          w_redirect_pc_nxt = w_trap_pc;
        end else if (mret_i && !w_irq_pend) begin
          w_state_nxt       = ST_MRET;
          w_mret_take       = 1'b1;
          w_redirect_nxt    = 1'b1;
          w_redirect_pc_nxt = r_mepc;
        end
      end
      ST_TRAP: w_state_nxt = ST_RUN;
      ST_MRET: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_RUN;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_redirect    <= w_redirect_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;

  // Architectural CSR state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_INI;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      if (w_trap_take) begin
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
        r_mepc    <= pc_i & ALIGN4;
        r_mcause  <= {1'b1, (XLEN-1)'(w_cause)};
      end else if (w_mret_take) begin
        r_st_mie  <= r_st_mpie;
        r_st_mpie <= 1'b1;
      end else if (w_we) begin
        case (csr_addr_i)
          ADDRW'(CSR_MSTATUS): begin
            r_st_mie  <= w_new[MSTATUS_MIE_BIT];
            r_st_mpie <= w_new[MSTATUS_MPIE_BIT];
          end
          ADDRW'(CSR_MIE):      r_mie      <= w_new & MIE_MASK;
          ADDRW'(CSR_MTVEC):    r_mtvec    <= VECTORED_EN ? w_new : (w_new & ALIGN4);
          ADDRW'(CSR_MSCRATCH): r_mscratch <= w_new;
          ADDRW'(CSR_MEPC):     r_mepc     <= w_new & ALIGN4;
          ADDRW'(CSR_MCAUSE):   r_mcause   <= w_new;
          default: ;
        endcase
      end
    end
  end

  csr_counter #(
    .CNT_W (CNT_W),
    .XLEN  (XLEN)
  ) u_mcycle (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_inc   (1'b1),
    .i_wr_lo (w_we && (csr_addr_i == ADDRW'(CSR_MCYCLE))),
    .i_wr_hi (w_we && (csr_addr_i == ADDRW'(CSR_MCYCLEH))),
    .i_wdata (w_new),
    .o_lo    (w_mcycle_lo),
    .o_hi    (w_mcycle_hi)
  );

  csr_counter #(
    .CNT_W (CNT_W),
    .XLEN  (XLEN)
  ) u_minstret (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_inc   (instr_ret_i && (r_state == ST_RUN)),
    .i_wr_lo (w_we && (csr_addr_i == ADDRW'(CSR_MINSTRET))),
    .i_wr_hi (w_we && (csr_addr_i == ADDRW'(CSR_MINSTRETH))),
    .i_wdata (w_new),
    .o_lo    (w_minstret_lo),
    .o_hi    (w_minstret_hi)
  );

endmodule
